// File: rtl/tron_cpu.sv
// tron_cpu: multicycle 16-bit load/store CPU core with an internal data RAM.
// One FSM state per cycle; instruction word is sampled from the port each fetch.
module tron_cpu #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [15:0] addressOut,
  output logic [15:0] busOutput
);

  localparam int unsigned W    = 16;
  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WB, S_JUMP, S_MEM
  } state_e;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_CMP, K_LUI, K_JAL, K_LOAD, K_STOR
  } kind_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q;
  logic [W-1:0]   ir_q;
  logic [W-1:0]   a_q;      // R[Rd] captured in DECODE
  logic [W-1:0]   b_q;      // R[Rs] captured in DECODE
  logic [W-1:0]   flags_q;
  logic [W-1:0]   rf_q [NREG];
  logic [W-1:0]   mem_q [DMEM_WORDS];
  logic [W-1:0]   rdata_q;

  // Instruction fields
  logic [3:0] op, ext, rd_f, rs_f;
  logic [W-1:0] imm_se, imm_ze;
  assign op     = ir_q[15:12];
  assign rd_f   = ir_q[11:8];
  assign ext    = ir_q[7:4];
  assign rs_f   = ir_q[3:0];
  assign imm_se = {{8{ir_q[7]}}, ir_q[7:0]};
  assign imm_ze = {8'h00, ir_q[7:0]};

  kind_e        kind;
  logic [3:0]   alu_code;
  logic [W-1:0] src;
  logic [W-1:0] result;
  logic [3:0]   rsh_amt;
  logic [W-1:0] flags_new;

  assign rsh_amt = 4'd0 - b_q[3:0];

  // Instruction classification and ALU/shifter result
  always_comb begin
    kind     = K_NOP;
    alu_code = op;
    src      = b_q;
    result   = '0;
    if (op == 4'h0) begin
      alu_code = ext;
      src      = b_q;
    end else if (op == 4'h5 || op == 4'h9 || op == 4'hB) begin
      src = imm_se;
    end else begin
      src = imm_ze;
    end
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: begin
        case (alu_code)
          4'h5: begin kind = K_ALU; result = W'(a_q + src); end
          4'h9: begin kind = K_ALU; result = W'(a_q - src); end
          4'hB: begin kind = K_CMP; result = W'(a_q - src); end
          4'h1: begin kind = K_ALU; result = a_q & src; end
          4'h2: begin kind = K_ALU; result = a_q | src; end
          4'h3: begin kind = K_ALU; result = a_q ^ src; end
          4'hD: begin kind = K_ALU; result = src; end
          default: kind = K_NOP;
        endcase
      end
      4'h8: begin
        if (ext == 4'h4) begin
          kind   = K_ALU;
          result = b_q[15] ? (a_q >> rsh_amt) : (a_q << b_q[3:0]);
        end else if (ext[3:1] == 3'b000) begin
          kind   = K_ALU;
          result = a_q << ir_q[3:0];
        end
      end
      4'h4: begin
        case (ext)
          4'h0: kind = K_LOAD;
          4'h4: kind = K_STOR;
          4'h8: begin kind = K_JAL; result = pc_q; end
          default: kind = K_NOP;
        endcase
      end
      4'hF: begin
        kind   = K_LUI;
        result = {ir_q[7:0], 8'h00};
      end
      default: kind = K_NOP;
    endcase
  end

  // Compare flags: N, Z, C=0, F=0, L
  logic lt_u, lt_s, eq;
  assign lt_u      = a_q < src;
  assign lt_s      = $signed(a_q) < $signed(src);
  assign eq        = a_q == src;
  assign flags_new = {11'b0, lt_s, eq, 1'b0, 1'b0, lt_u};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (kind)
          K_LUI:          state_d = S_WB;
          K_JAL:          state_d = S_JUMP;
          K_LOAD, K_STOR: state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  logic         reg_write_c, mem_write_c, flag_write_c;
  logic [W-1:0] bus_c, addr_c;

  // Output and strobe decode per state
  always_comb begin
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    flag_write_c = 1'b0;
    bus_c        = '0;
    addr_c       = pc_q;
    case (state_q)
      S_EXECUTE: begin
        case (kind)
          K_ALU: begin reg_write_c = 1'b1; bus_c = result; end
          K_CMP: flag_write_c = 1'b1;
          K_JAL: begin reg_write_c = 1'b1; bus_c = pc_q; end
          default: ;
        endcase
      end
      S_WB: begin
        reg_write_c = 1'b1;
        bus_c       = result;
      end
      S_MEM: begin
        addr_c = b_q;
        if (kind == K_STOR) begin
          mem_write_c = 1'b1;
          bus_c       = a_q;
        end else begin
          reg_write_c = 1'b1;
          bus_c       = rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign addressOut = addr_c;
  assign busOutput  = bus_c;

  // PC, instruction, operand and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
    end else begin
      if (state_q == S_FETCH) ir_q <= instruction;
      if (state_q == S_DECODE) begin
        a_q  <= rf_q[rd_f];
        b_q  <= rf_q[rs_f];
        pc_q <= W'(pc_q + 16'd1);
      end
      if (state_q == S_EXECUTE && kind == K_JAL) pc_q <= b_q;
      if (flag_write_c) flags_q <= flags_new;
    end
  end

  // Register file, reset to R[n]=n
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= W'(i);
    end else if (reg_write_c) begin
      rf_q[rd_f] <= bus_c;
    end
  end

  // Data RAM with synchronous read; the address is stable from DECODE onward
  always_ff @(posedge clk) begin
    if (mem_write_c) mem_q[b_q[AW-1:0]] <= a_q;
    rdata_q <= mem_q[b_q[AW-1:0]];
  end

endmodule

// File: tb/tb_tron_cpu.sv
// Directed bench for tron_cpu: each case starts from reset register values.
module tb_tron_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] addressOut;
  logic [15:0] busOutput;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  tron_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    instruction = 16'h0000;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Apply an instruction at FETCH and advance into EXECUTE
  task automatic to_exec(input logic [15:0] ins);
    instruction = ins;
    tick();
    tick();
  endtask

  task automatic alu_case(input string tag, input logic [15:0] ins, input logic [15:0] exp);
    do_reset();
    to_exec(ins);
    check(tag, busOutput, exp);
    check({tag, "_rw"}, 16'(dut.reg_write_c), 16'h0001);
    tick();
    check({tag, "_rd"}, dut.rf_q[1], exp);
    check({tag, "_pc"}, dut.pc_q, 16'h0001);
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    do_reset();

    // Reset state
    check("rst_addr", addressOut, 16'h0000);
    check("rst_bus", busOutput, 16'h0000);
    check("rst_flags", dut.flags_q, 16'h0000);
    check("rst_r7", dut.rf_q[7], 16'h0007);

    // ALU ops
    alu_case("add",  16'h0152, 16'h0003);
    alu_case("addi", 16'h5193, 16'hFF94);
    alu_case("sub",  16'h0192, 16'hFFFF);
    alu_case("xor",  16'h013E, 16'h000F);
    alu_case("ori",  16'h210E, 16'h000F);
    alu_case("lsh",  16'h8143, 16'h0008);
    alu_case("lshi0", 16'h8101, 16'h0002);
    alu_case("lshi1", 16'h8111, 16'h0002);

    // CMP: flags only, no register write
    do_reset();
    to_exec(16'h01B1);
    check("cmp_rw", 16'(dut.reg_write_c), 16'h0000);
    tick();
    check("cmp_flags", dut.flags_q, 16'h0008);
    check("cmp_r1", dut.rf_q[1], 16'h0001);

    do_reset();
    to_exec(16'hB102);
    tick();
    check("cmpi_flags", dut.flags_q, 16'h0011);

    // LUI takes a WB cycle
    do_reset();
    to_exec(16'hF101);
    check("lui_ex_rw", 16'(dut.reg_write_c), 16'h0000);
    tick();
    check("lui_wb_bus", busOutput, 16'h0100);
    check("lui_wb_rw", 16'(dut.reg_write_c), 16'h0001);
    tick();
    check("lui_r1", dut.rf_q[1], 16'h0100);
    check("lui_pc", dut.pc_q, 16'h0001);

    // JAL from PC=0x22
    do_reset();
    for (int k = 0; k < 34; k++) begin
      instruction = 16'h0000;
      tick(); tick(); tick();
    end
    check("nop_pc", dut.pc_q, 16'h0022);
    to_exec(16'h4182);
    check("jal_link", busOutput, 16'h0023);
    check("jal_rw", 16'(dut.reg_write_c), 16'h0001);
    tick();
    check("jal_jump_addr", addressOut, 16'h0002);
    check("jal_jump_bus", busOutput, 16'h0000);
    tick();
    check("jal_r1", dut.rf_q[1], 16'h0023);
    check("jal_pc", dut.pc_q, 16'h0002);

    // STOR then LOAD
    do_reset();
    to_exec(16'h4541);
    tick();
    check("stor_mw", 16'(dut.mem_write_c), 16'h0001);
    check("stor_bus", busOutput, 16'h0005);
    check("stor_addr", addressOut, 16'h0001);
    tick();
    to_exec(16'h4101);
    tick();
    check("load_rw", 16'(dut.reg_write_c), 16'h0001);
    check("load_bus", busOutput, 16'h0005);
    check("load_addr", addressOut, 16'h0001);
    tick();
    check("load_r1", dut.rf_q[1], 16'h0005);

    // Right shift, then JAL to 0xFFFF and PC wrap
    do_reset();
    to_exec(16'h9001);
    check("subi_r0", busOutput, 16'hFFFF);
    tick();
    to_exec(16'h8240);
    check("lsh_right", busOutput, 16'h0001);
    tick();
    to_exec(16'h4180);
    tick();
    check("jal_ffff", addressOut, 16'hFFFF);
    tick();
    instruction = 16'h0000;
    tick(); tick(); tick();
    check("pc_wrap", dut.pc_q, 16'h0000);

    // Reset during EXECUTE aborts the write
    do_reset();
    to_exec(16'hD1AB);
    check("movi_ex", busOutput, 16'h00AB);
    #2 reset = 1'b0;
    #1;
    check("abort_pc", dut.pc_q, 16'h0000);
    check("abort_addr", addressOut, 16'h0000);
    tick();
    check("abort_r1", dut.rf_q[1], 16'h0001);
    reset = 1'b1;

    // Back-to-back MOVI: one PC step per three cycles
    for (int i = 1; i <= 3; i++) begin
      to_exec(16'hD101);
      tick();
      check("b2b_pc", dut.pc_q, 16'(i));
    end
    check("b2b_r1", dut.rf_q[1], 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
